// File: rtl/bypass_network.sv
// Operand-forwarding and load-use hazard block tracking the last DEPTH producer stages.
// Optional perf counters (stall_cnt_o, fwd_cnt_o) are built when BYPASS_PERF_EN is defined.
module bypass_network #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic                  issue_we_i,
  input  logic                  issue_load_i,
  input  logic                  flush_i,
  input  logic [NRD*AW-1:0]     rs_i,
  input  logic [NRD*XLEN-1:0]   rdata_i,
  input  logic [DEPTH*XLEN-1:0] stage_data_i,
  output logic [NRD*XLEN-1:0]   op_o,
  output logic [NRD*SW-1:0]     fwd_sel_o,
  output logic                  stall_o
`ifdef BYPASS_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           fwd_cnt_o
`endif
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0]         ld_q, ld_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;

  // Scan oldest to youngest so the lowest-numbered matching stage is the one left standing.
  always_comb begin
    op_o      = rdata_i;
    fwd_sel_o = '0;
    for (int unsigned n = 0; n < NRD; n++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld_q[DEPTH-1-i] && (rd_q[DEPTH-1-i] != '0) &&
            (rd_q[DEPTH-1-i] == rs_i[n*AW +: AW])) begin
          fwd_sel_o[n*SW +: SW] = SW'(DEPTH - i);
          op_o[n*XLEN +: XLEN]  = stage_data_i[(DEPTH-1-i)*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    stall_o = 1'b0;
    for (int unsigned n = 0; n < NRD; n++) begin
      if ((fwd_sel_o[n*SW +: SW] == SW'(1)) && ld_q[0]) stall_o = 1'b1;
    end
  end

  // A flush kills both the offered issue and the entry leaving stage 0.
  always_comb begin
    vld_d[0] = issue_valid_i & issue_we_i & ~stall_o & ~flush_i;
    rd_d[0]  = issue_rd_i;
    ld_d[0]  = issue_load_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      ld_d[k]  = ld_q[k-1];
    end
    vld_d[1] = vld_q[0] & ~flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
    end
  end

`ifdef BYPASS_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_o) stall_cnt_d = stall_cnt_q + 32'd1;
    else if (|fwd_sel_o) fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_bypass_network.sv
// Scoreboard bench for bypass_network: stimulus pushes model expectations, a negedge monitor checks.
module tb_bypass_network;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NRD   = 2;
  localparam int SW    = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  issue_valid_i = 1'b0;
  logic [AW-1:0]         issue_rd_i = '0;
  logic                  issue_we_i = 1'b0;
  logic                  issue_load_i = 1'b0;
  logic                  flush_i = 1'b0;
  logic [NRD*AW-1:0]     rs_i = '0;
  logic [NRD*XLEN-1:0]   rdata_i = '0;
  logic [DEPTH*XLEN-1:0] stage_data_i = '0;
  logic [NRD*XLEN-1:0]   op_o;
  logic [NRD*SW-1:0]     fwd_sel_o;
  logic                  stall_o;
`ifdef BYPASS_PERF_EN
  logic [31:0]           stall_cnt_o;
  logic [31:0]           fwd_cnt_o;
`endif

  bypass_network #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i),
    .issue_load_i(issue_load_i), .flush_i(flush_i),
    .rs_i(rs_i), .rdata_i(rdata_i), .stage_data_i(stage_data_i),
    .op_o(op_o), .fwd_sel_o(fwd_sel_o), .stall_o(stall_o)
`ifdef BYPASS_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          v;
    logic [4:0]  rd;
    bit          ld;
  } ent_t;

  typedef struct {
    logic [NRD*XLEN-1:0] op;
    logic [NRD*SW-1:0]   sel;
    logic                stall;
    logic [31:0]         scnt;
    logic [31:0]         fcnt;
    int                  id;
  } exp_t;

  ent_t        hist[$];   // hist[0] is the youngest in-flight instruction
  exp_t        exp_q[$];
  logic [31:0] m_scnt, m_fcnt;
  int          checks = 0;
  int          errors = 0;
  int          vec_id = 0;

  function automatic int unsigned youngest_match(input logic [4:0] r);
    for (int i = 0; i < DEPTH; i++)
      if (hist[i].v && r != 5'd0 && hist[i].rd == r) return i + 1;
    return 0;
  endfunction

  function automatic exp_t predict(input logic [4:0] r0, input logic [4:0] r1,
                                   input logic [NRD*XLEN-1:0] rdat,
                                   input logic [DEPTH*XLEN-1:0] sd);
    exp_t e;
    int unsigned s[2];
    logic [XLEN-1:0] o[2];
    s[0] = youngest_match(r0);
    s[1] = youngest_match(r1);
    for (int n = 0; n < 2; n++)
      o[n] = (s[n] == 0) ? rdat[n*XLEN +: XLEN] : sd[(s[n]-1)*XLEN +: XLEN];
    e.op    = {o[1], o[0]};
    e.sel   = {SW'(s[1]), SW'(s[0])};
    e.stall = ((s[0] == 1) || (s[1] == 1)) && hist[0].ld;
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    e.id    = vec_id;
    return e;
  endfunction

  task automatic clear_model();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back('0);
    m_scnt = '0;
    m_fcnt = '0;
  endtask

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("op0", e.id, 64'(op_o[XLEN-1:0]), 64'(e.op[XLEN-1:0]));
        check("op1", e.id, 64'(op_o[2*XLEN-1:XLEN]), 64'(e.op[2*XLEN-1:XLEN]));
        check("fwd_sel", e.id, 64'(fwd_sel_o), 64'(e.sel));
        check("stall", e.id, 64'(stall_o), 64'(e.stall));
`ifdef BYPASS_PERF_EN
        check("stall_cnt", e.id, 64'(stall_cnt_o), 64'(e.scnt));
        check("fwd_cnt", e.id, 64'(fwd_cnt_o), 64'(e.fcnt));
`endif
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic drive(input bit v, input logic [4:0] rd, input bit we, input bit ld, input bit fl,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [NRD*XLEN-1:0] rdat, input logic [DEPTH*XLEN-1:0] sd);
    exp_t e;
    ent_t n;
    issue_valid_i = v; issue_rd_i = rd; issue_we_i = we; issue_load_i = ld; flush_i = fl;
    rs_i = {r1, r0}; rdata_i = rdat; stage_data_i = sd;
    e = predict(r0, r1, rdat, sd);
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    if (e.stall) m_scnt = m_scnt + 32'd1;
    else if (e.sel != '0) m_fcnt = m_fcnt + 32'd1;
    if (fl) hist[0].v = 1'b0;
    n.v = v && we && !e.stall && !fl;
    n.rd = rd;
    n.ld = ld;
    hist.push_front(n);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic do_reset(input logic [4:0] r0, input logic [4:0] r1, input logic [NRD*XLEN-1:0] rdat);
    rst = 1'b1;
    clear_model();
    issue_valid_i = 1'b0; flush_i = 1'b0;
    rs_i = {r1, r0}; rdata_i = rdat; stage_data_i = {$urandom, $urandom, $urandom};
    exp_q.push_back(predict(r0, r1, rdat, stage_data_i));
    vec_id++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [DEPTH*XLEN-1:0] rsd();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NRD*XLEN-1:0] rrd();
    return {$urandom, $urandom};
  endfunction

  localparam logic [DEPTH*XLEN-1:0] SD_A = {32'h11, 32'h22, 32'h33};

  initial begin
    clear_model();
    @(posedge clk);
    #1;
    do_reset(5'd5, 5'd3, {32'hBBBB, 32'hAAAA});

    // EX forwarding and youngest-wins priority
    drive(1, 5'd5, 1, 0, 0, 5'd0, 5'd0, rrd(), rsd());
    drive(1, 5'd5, 1, 0, 0, 5'd0, 5'd0, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd5, 5'd0, rrd(), SD_A);
    drive(0, 5'd0, 0, 0, 0, 5'd5, 5'd0, rrd(), SD_A);

    // x0 is never forwarded
    drive(1, 5'd0, 1, 0, 0, 5'd0, 5'd0, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd0, 5'd0, rrd(), rsd());

    // Load-use: one stall cycle, then forward from stage 1
    drive(1, 5'd7, 1, 1, 0, 5'd0, 5'd0, rrd(), rsd());
    drive(1, 5'd8, 1, 0, 0, 5'd0, 5'd7, rrd(), rsd());
    drive(1, 5'd8, 1, 0, 0, 5'd0, 5'd7, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd8, 5'd7, rrd(), rsd());

    // Flush squashes the offered issue
    drive(1, 5'd9, 1, 0, 1, 5'd0, 5'd0, rrd(), rsd());
    for (int i = 0; i < DEPTH; i++) drive(0, 5'd0, 0, 0, 0, 5'd9, 5'd0, rrd(), rsd());

    // Stall together with flush: nothing enters, stage-0 load is squashed
    drive(1, 5'd10, 1, 1, 0, 5'd0, 5'd0, rrd(), rsd());
    drive(1, 5'd11, 1, 0, 1, 5'd10, 5'd0, rrd(), rsd());
    for (int i = 0; i < DEPTH; i++) drive(0, 5'd0, 0, 0, 0, 5'd10, 5'd11, rrd(), rsd());

    // Load-use followed by forwarded cycles, then reset mid-sequence
    do_reset(5'd1, 5'd2, rrd());
    drive(1, 5'd7, 1, 1, 0, 5'd0, 5'd0, rrd(), rsd());
    drive(1, 5'd6, 1, 0, 0, 5'd0, 5'd7, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd6, 5'd7, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd6, 5'd7, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd6, 5'd0, rrd(), rsd());
    drive(0, 5'd0, 0, 0, 0, 5'd6, 5'd7, rrd(), rsd());
    do_reset(5'd6, 5'd7, rrd());
    drive(0, 5'd0, 0, 0, 0, 5'd6, 5'd7, rrd(), rsd());

    // Randomized traffic over a small register range to provoke matches
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rrd());
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rrd(), rsd());
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", vec_id, 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
